// File: rtl/skeeball_game_ctrl.sv
// rtl/skeeball_game_ctrl.sv - synchronous skeeball scorer: hole edge detect, per-ball lockout,
// saturating score, game-over flag and persistent high score.
module skeeball_game_ctrl #(
   parameter int NUM_BALLS   = 9,
   parameter int SCORE_W     = 8,
   parameter int LOCKOUT_CYC = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [6:0]           holes,
   output logic [NUM_BALLS-1:0] balls,
   output logic [SCORE_W-1:0]   score,
   output logic [SCORE_W-1:0]   high_score,
   output logic                 game_over,
   output logic                 new_high,
   output logic                 ball_pulse,
   output logic [3:0]           ball_pts
);

   localparam int CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
   localparam logic [CNT_W-1:0] LOCK_INIT = CNT_W'((LOCKOUT_CYC > 0) ? LOCKOUT_CYC - 1 : 0);
   localparam logic [NUM_BALLS-1:0] LAST_BALL = NUM_BALLS'(1);

   typedef enum logic [1:0] {IDLE, PLAY, LOCK, OVER} state_t;

   state_t               state, state_d;
   logic [6:0]           hole_q;
   logic [6:0]           rise;
   logic                 any_rise;
   logic [3:0]           pts;
   logic [CNT_W-1:0]     cnt, cnt_d;
   logic [SCORE_W:0]     sum;
   logic [SCORE_W-1:0]   sat;
   logic [NUM_BALLS-1:0] balls_d;
   logic [SCORE_W-1:0]   score_d, high_d;
   logic                 over_d, new_high_d, pulse_d;
   logic [3:0]           pts_d;

   assign rise     = holes & ~hole_q;
   assign any_rise = |rise;

   // Simultaneous rises collapse to one ball worth the highest hole.
   always_comb begin
      pts = 4'd0;
      if      (rise[6]) pts = 4'd10;
      else if (rise[5]) pts = 4'd5;
      else if (rise[4]) pts = 4'd4;
      else if (rise[3]) pts = 4'd3;
      else if (rise[2]) pts = 4'd2;
      else if (rise[1]) pts = 4'd1;
   end

   assign sum = {1'b0, score} + {{(SCORE_W-3){1'b0}}, pts};
   assign sat = sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];

   always_comb begin
      state_d    = state;
      cnt_d      = cnt;
      balls_d    = balls;
      score_d    = score;
      high_d     = high_score;
      over_d     = game_over;
      new_high_d = new_high;
      pulse_d    = 1'b0;
      pts_d      = 4'd0;
      if (start) begin
         state_d    = PLAY;
         cnt_d      = '0;
         balls_d    = {NUM_BALLS{1'b1}};
         score_d    = '0;
         over_d     = 1'b0;
         new_high_d = 1'b0;
      end else begin
         case (state)
            PLAY: begin
               if (any_rise) begin
                  score_d = sat;
                  balls_d = balls >> 1;
                  pulse_d = 1'b1;
                  pts_d   = pts;
                  if (balls == LAST_BALL) begin
                     state_d = OVER;
                     over_d  = 1'b1;
                     if (sat > high_score) begin
                        high_d     = sat;
                        new_high_d = 1'b1;
                     end
                  end else if (LOCKOUT_CYC > 0) begin
                     state_d = LOCK;
                     cnt_d   = LOCK_INIT;
                  end
               end
            end
            LOCK: begin
               if (cnt == '0) state_d = PLAY;
               else           cnt_d   = cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         hole_q     <= '0;
         cnt        <= '0;
         balls      <= '0;
         score      <= '0;
         high_score <= '0;
         game_over  <= 1'b0;
         new_high   <= 1'b0;
         ball_pulse <= 1'b0;
         ball_pts   <= 4'd0;
      end else begin
         state      <= state_d;
         hole_q     <= holes;
         cnt        <= cnt_d;
         balls      <= balls_d;
         score      <= score_d;
         high_score <= high_d;
         game_over  <= over_d;
         new_high   <= new_high_d;
         ball_pulse <= pulse_d;
         ball_pts   <= pts_d;
      end
   end

endmodule

// File: tb/tb_skeeball_game_ctrl.sv
// tb/tb_skeeball_game_ctrl.sv - scoreboard bench for skeeball_game_ctrl.
module tb_skeeball_game_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [6:0] holes = '0;
   logic       start4 = 1'b0;
   logic [6:0] holes4 = '0;

   logic [8:0] balls;
   logic [7:0] score, high_score;
   logic       game_over, new_high, ball_pulse;
   logic [3:0] ball_pts;

   logic [2:0] balls4;
   logic [3:0] score4, high_score4;
   logic       game_over4, new_high4, ball_pulse4;
   logic [3:0] ball_pts4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] pts;
      logic [7:0] score;
      logic [8:0] balls;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   logic [7:0] m_score;
   logic [8:0] m_balls;

   skeeball_game_ctrl #(.NUM_BALLS(9), .SCORE_W(8), .LOCKOUT_CYC(4)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .holes(holes),
      .balls(balls), .score(score), .high_score(high_score),
      .game_over(game_over), .new_high(new_high),
      .ball_pulse(ball_pulse), .ball_pts(ball_pts)
   );

   skeeball_game_ctrl #(.NUM_BALLS(3), .SCORE_W(4), .LOCKOUT_CYC(0)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .holes(holes4),
      .balls(balls4), .score(score4), .high_score(high_score4),
      .game_over(game_over4), .new_high(new_high4),
      .ball_pulse(ball_pulse4), .ball_pts(ball_pts4)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n && ball_pulse) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got pts=%0d score=%0d, required no pulse", ball_pts, score);
         end else begin
            mon_e = exp_q.pop_front();
            if (ball_pts !== mon_e.pts || score !== mon_e.score || balls !== mon_e.balls) begin
               errors++;
               $display("FAIL ball_event: got pts=%0d score=%0d balls=%h, required pts=%0d score=%0d balls=%h",
                        ball_pts, score, balls, mon_e.pts, mon_e.score, mon_e.balls);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_ball(input int p);
      exp_t e;
      int   s;
      s       = int'(m_score) + p;
      m_score = (s > 255) ? 8'hFF : 8'(s);
      m_balls = m_balls >> 1;
      e.pts   = 4'(p);
      e.score = m_score;
      e.balls = m_balls;
      exp_q.push_back(e);
   endtask

   task automatic ball_mask(input logic [6:0] mask, input int p, input bit accept);
      @(negedge clk);
      holes = mask;
      if (accept) push_ball(p);
      @(negedge clk);
      holes = '0;
   endtask

   task automatic ball(input int b, input bit accept);
      logic [6:0] m;
      m = 7'd1 << b;
      ball_mask(m, (b == 6) ? 10 : b, accept);
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      m_score = '0;
      m_balls = '1;
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      tick(2);
      checks++;
      if ({balls, score, high_score, game_over, new_high, ball_pulse, ball_pts} !== '0) begin
         errors++;
         $display("FAIL reset_state: got balls=%h score=%0d high=%0d over=%b nh=%b pulse=%b pts=%0d, required all 0",
                  balls, score, high_score, game_over, new_high, ball_pulse, ball_pts);
      end
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_first_ball();
      do_start();
      checks++;
      if (balls !== 9'h1FF || score !== 8'd0 || game_over !== 1'b0) begin
         errors++;
         $display("FAIL start_init: got balls=%h score=%0d over=%b, required 1ff 0 0", balls, score, game_over);
      end
      ball(6, 1);
      tick(5);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL first_ball_missing: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_held();
      @(negedge clk);
      holes = 7'h08;
      push_ball(3);
      tick(20);
      holes = '0;
      tick(5);
      checks++;
      if (score !== 8'd13 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL held_sensor: got score=%0d pending=%0d, required 13 0", score, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_lockout();
      @(negedge clk); holes = 7'h04; push_ball(2);
      @(negedge clk); holes = 7'h00;
      @(negedge clk); holes = 7'h20;
      @(negedge clk); holes = 7'h00;
      @(negedge clk);
      @(negedge clk); holes = 7'h20; push_ball(5);
      @(negedge clk); holes = 7'h00;
      tick(5);
      checks++;
      if (score !== 8'd20 || balls !== 9'h01F || exp_q.size() != 0) begin
         errors++;
         $display("FAIL lockout: got score=%0d balls=%h pending=%0d, required 20 01f 0", score, balls, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_game_over();
      do_start();
      for (int i = 0; i < 9; i++) begin
         ball(6, 1);
         tick(4);
      end
      checks++;
      if (game_over !== 1'b1 || score !== 8'd90 || balls !== 9'h000 ||
          high_score !== 8'd90 || new_high !== 1'b1) begin
         errors++;
         $display("FAIL game_over_90: got over=%b score=%0d balls=%h high=%0d nh=%b, required 1 90 000 90 1",
                  game_over, score, balls, high_score, new_high);
      end
      ball(6, 0);
      tick(2);
      checks++;
      if (score !== 8'd90 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL over_ignores: got score=%0d pending=%0d, required 90 0", score, exp_q.size());
         exp_q.delete();
      end
      do_start();
      checks++;
      if (game_over !== 1'b0 || new_high !== 1'b0 || high_score !== 8'd90) begin
         errors++;
         $display("FAIL restart_flags: got over=%b nh=%b high=%0d, required 0 0 90", game_over, new_high, high_score);
      end
      for (int i = 0; i < 9; i++) begin
         ball(0, 1);
         tick(4);
      end
      checks++;
      if (game_over !== 1'b1 || score !== 8'd0 || high_score !== 8'd90 || new_high !== 1'b0) begin
         errors++;
         $display("FAIL gutter_game: got over=%b score=%0d high=%0d nh=%b, required 1 0 90 0",
                  game_over, score, high_score, new_high);
      end
   endtask

   task automatic test_multi();
      do_start();
      ball_mask(7'b1000010, 10, 1);
      tick(5);
      checks++;
      if (score !== 8'd10 || balls !== 9'h0FF || exp_q.size() != 0) begin
         errors++;
         $display("FAIL multi_rise: got score=%0d balls=%h pending=%0d, required 10 0ff 0", score, balls, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_start_priority();
      @(negedge clk);
      start = 1'b1;
      holes = 7'h20;
      @(negedge clk);
      start   = 1'b0;
      holes   = '0;
      m_score = '0;
      m_balls = '1;
      checks++;
      if (balls !== 9'h1FF || score !== 8'd0 || ball_pulse !== 1'b0) begin
         errors++;
         $display("FAIL start_priority: got balls=%h score=%0d pulse=%b, required 1ff 0 0", balls, score, ball_pulse);
      end
      tick(3);
   endtask

   task automatic test_saturation();
      @(negedge clk); start4 = 1'b1;
      @(negedge clk); start4 = 1'b0;
      @(negedge clk); holes4 = 7'h40;
      @(negedge clk); holes4 = 7'h00;
      checks++;
      if (score4 !== 4'd10 || ball_pulse4 !== 1'b1 || ball_pts4 !== 4'd10) begin
         errors++;
         $display("FAIL sat_first: got score=%0d pulse=%b pts=%0d, required 10 1 10", score4, ball_pulse4, ball_pts4);
      end
      @(negedge clk); holes4 = 7'h40;
      @(negedge clk); holes4 = 7'h00;
      checks++;
      if (score4 !== 4'd15 || balls4 !== 3'b001) begin
         errors++;
         $display("FAIL sat_clamp: got score=%0d balls=%b, required 15 001", score4, balls4);
      end
      @(negedge clk); holes4 = 7'h40;
      @(negedge clk); holes4 = 7'h00;
      checks++;
      if (score4 !== 4'd15 || game_over4 !== 1'b1 || high_score4 !== 4'd15 || new_high4 !== 1'b1) begin
         errors++;
         $display("FAIL sat_over: got score=%0d over=%b high=%0d nh=%b, required 15 1 15 1",
                  score4, game_over4, high_score4, new_high4);
      end
   endtask

   task automatic test_reset_mid_lock();
      ball(6, 1);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({balls, score, high_score, game_over, new_high, ball_pulse, ball_pts} !== '0) begin
         errors++;
         $display("FAIL reset_mid_lock: got balls=%h score=%0d high=%0d over=%b nh=%b pulse=%b pts=%0d, required all 0",
                  balls, score, high_score, game_over, new_high, ball_pulse, ball_pts);
      end
      tick(2);
      rst_n = 1'b1;
      tick(2);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL reset_lock_event: got %0d pending, required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   initial begin
      m_score = '0;
      m_balls = '0;
      test_reset();
      test_first_ball();
      test_held();
      test_lockout();
      test_game_over();
      test_multi();
      tick(5);
      test_start_priority();
      test_saturation();
      test_reset_mid_lock();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
